data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 129 ++++++++++++
 tb/tb_data_mem_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-port word memory behind a request/commit controller
// for the writeback stage.
//
// Handshake: a request (wr_req_i / rd_req_i) is held high by the requester
// until it is accepted. Acceptance happens only at a rising edge while the
// controller is IDLE (busy_o low). Write wins when both are high. After
// acceptance the controller waits LATENCY cycles, commits the access, shows
// one RESP cycle (rd_valid_o / err_o pulse there), and returns to IDLE.
//
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   wr_req_i        - write request; wr_addr_i / wr_data_i / wr_byte_i
//   rd_req_i        - read request; rd_addr_i
//   rd_data_o       - last read word, held until the next read commits
//   rd_valid_o      - one-cycle pulse in the RESP cycle of a read
//   wr_valid_o      - low while a write is in flight (WAIT..RESP)
//   busy_o          - high in WAIT and RESP
//   err_o           - one-cycle pulse in RESP of an out-of-range access
//   dbg_state_o     - current FSM state, for observation only
module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_req_i,
    input  logic [31:0] wr_addr_i,
    input  logic [31:0] wr_data_i,
    input  logic [3:0]  wr_byte_i,
    input  logic        rd_req_i,
    input  logic [31:0] rd_addr_i,
    output logic [31:0] rd_data_o,
    output logic        rd_valid_o,
    output logic        wr_valid_o,
    output logic        busy_o,
    output logic        err_o,
    output logic [1:0]  dbg_state_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        op_wr;      // latched operation: 1 = write, 0 = read
    logic [29:0] waddr_q;    // latched word address (byte address >> 2)
    logic [31:0] wdata_q;
    logic [3:0]  wbyte_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0] idx;
    logic             oor;
    logic             commit;

    // Byte-offset bits never select anything; kept visible only so they are
    // not reported as dangling inputs.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{wr_addr_i[1:0], rd_addr_i[1:0]};

    assign idx    = waddr_q[IDX_W-1:0];
    // Any set bit above the index range makes the access out of range.
    assign oor    = |(waddr_q >> IDX_W);
    assign commit = (state == S_WAIT) && (cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            op_wr     <= 1'b0;
            waddr_q   <= 30'd0;
            wdata_q   <= 32'd0;
            wbyte_q   <= 4'd0;
            rd_data_o <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (wr_req_i) begin
                        op_wr   <= 1'b1;
                        waddr_q <= wr_addr_i[31:2];
                        wdata_q <= wr_data_i;
                        wbyte_q <= wr_byte_i;
                        cnt     <= 4'(LATENCY - 1);
                        state   <= S_WAIT;
                    end else if (rd_req_i) begin
                        op_wr   <= 1'b0;
                        waddr_q <= rd_addr_i[31:2];
                        cnt     <= 4'(LATENCY - 1);
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_RESP;
                        if (!op_wr) begin
                            rd_data_o <= oor ? 32'd0 : mem[idx];
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Memory is not reset; a reset during WAIT suppresses the commit so an
    // aborted write never reaches the array.
    always_ff @(posedge clk) begin
        if (!reset && commit && op_wr && !oor) begin
            for (int n = 0; n < 4; n++) begin
                if (wbyte_q[n]) begin
                    mem[idx][8*n +: 8] <= wdata_q[8*n +: 8];
                end
            end
        end
    end

    assign busy_o      = (state != S_IDLE);
    assign wr_valid_o  = !(busy_o && op_wr);
    assign rd_valid_o  = (state == S_RESP) && !op_wr;
    assign err_o       = (state == S_RESP) && oor;
    assign dbg_state_o = state;

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_req, rd_req;
    logic [31:0] wr_addr, wr_data, rd_addr;
    logic [3:0]  wr_byte;
    logic [31:0] rd_data_o;
    logic        rd_valid_o, wr_valid_o, busy_o, err_o;
    logic [1:0]  dbg_state_o;

    int checks = 0;
    int errors = 0;

    // Scoreboard entry: {rd_valid, err, read data (0 unless a read)}
    logic [33:0] exp_q[$];
    logic [33:0] mon_got;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_byte_i(wr_byte),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .wr_valid_o(wr_valid_o),
        .busy_o(busy_o), .err_o(err_o), .dbg_state_o(dbg_state_o)
    );

    // Two extra instances used only for latency/throughput spacing.
    logic [1:0]  l_req;
    logic [1:0]  l_busy, l_rv, l_wv, l_err;
    logic [31:0] l_data [2];
    logic [1:0]  l_dbg  [2];

    data_mem_ctrl #(.DEPTH_WORDS(1024), .LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset),
        .wr_req_i(1'b0), .wr_addr_i(32'h0), .wr_data_i(32'h0), .wr_byte_i(4'h0),
        .rd_req_i(l_req[0]), .rd_addr_i(32'h4),
        .rd_data_o(l_data[0]), .rd_valid_o(l_rv[0]), .wr_valid_o(l_wv[0]),
        .busy_o(l_busy[0]), .err_o(l_err[0]), .dbg_state_o(l_dbg[0])
    );

    data_mem_ctrl #(.DEPTH_WORDS(1024), .LATENCY(8)) dut_l8 (
        .clk(clk), .reset(reset),
        .wr_req_i(1'b0), .wr_addr_i(32'h0), .wr_data_i(32'h0), .wr_byte_i(4'h0),
        .rd_req_i(l_req[1]), .rd_addr_i(32'h4),
        .rd_data_o(l_data[1]), .rd_valid_o(l_rv[1]), .wr_valid_o(l_wv[1]),
        .busy_o(l_busy[1]), .err_o(l_err[1]), .dbg_state_o(l_dbg[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_oor(input logic [31:0] a);
        return a >= 32'h0000_1000;
    endfunction

    // Monitor: every rd_valid/err pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && (rd_valid_o || err_o)) begin
            mon_got = {rd_valid_o, err_o, rd_valid_o ? rd_data_o : 32'h0};
            if (exp_q.size() == 0) chk("unexpected_pulse", 64'(mon_got), 64'h0);
            else                   chk("response", 64'(mon_got), 64'(exp_q.pop_front()));
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy_o) chk("idle_timeout", 1, 0);
    endtask

    // Issue one request and follow it to IDLE. Accept cycle is cycle 0;
    // busy_n counts busy cycles, rv_at is the cycle index of rd_valid_o.
    task automatic do_access(input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be, output int busy_n, output int wrv_low,
                             output int rv_at);
        wait_idle();
        if (is_wr) begin
            wr_req = 1'b1; wr_addr = a; wr_data = d; wr_byte = be;
        end else begin
            rd_req = 1'b1; rd_addr = a;
        end
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b0;
        // Scramble inputs while busy; only latched values may be used.
        wr_addr = 32'h0000_0010; wr_data = 32'hFFFF_FFFF; wr_byte = 4'hF; rd_addr = 32'h0000_1000;
        busy_n = 0; wrv_low = 0; rv_at = 0;
        while (busy_o && busy_n < 20) begin
            busy_n++;
            if (!wr_valid_o) wrv_low++;
            if (rd_valid_o) rv_at = busy_n;
            @(negedge clk);
        end
    endtask

    int bn, wl, rv;

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        if (is_oor(a)) exp_q.push_back({1'b0, 1'b1, 32'h0});
        do_access(1'b1, a, d, be, bn, wl, rv);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp);
        exp_q.push_back({1'b1, is_oor(a), is_oor(a) ? 32'h0 : exp});
        do_access(1'b0, a, 32'h0, 4'h0, bn, wl, rv);
    endtask

    int last_acc [2];
    int prev_acc [2];
    int pulses   [2];
    int lat      [2];

    initial begin
        reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0; l_req = 2'b00;
        wr_addr = 32'h0; wr_data = 32'h0; wr_byte = 4'h0; rd_addr = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_wr_valid", wr_valid_o, 1);
        chk("rst_rd_valid", rd_valid_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_rd_data", rd_data_o, 0);
        reset = 1'b0;
        @(negedge clk);

        // Full write then read with timing.
        wr(32'h10, 32'hDEADBEEF, 4'b1111);
        chk("wr_busy_cycles", bn, 3);
        chk("wr_valid_low_cycles", wl, 3);
        rd(32'h10, 32'hDEADBEEF);
        chk("rd_busy_cycles", bn, 3);
        chk("rd_valid_cycle", rv, 3);
        chk("rd_wr_valid_low", wl, 0);

        // Partial-lane write.
        wr(32'h10, 32'h11223344, 4'b0101);
        rd(32'h10, 32'hDE22BE44);
        // Empty lane mask and ignored byte offset.
        wr(32'h10, 32'h99999999, 4'b0000);
        chk("wr_nolane_busy", bn, 3);
        rd(32'h13, 32'hDE22BE44);

        // Simultaneous requests: write wins, read follows and sees new data.
        wr(32'h20, 32'h0, 4'hF);
        wait_idle();
        wr_req = 1'b1; rd_req = 1'b1; wr_addr = 32'h20; rd_addr = 32'h20;
        wr_data = 32'hA5A5A5A5; wr_byte = 4'hF;
        exp_q.push_back({1'b1, 1'b0, 32'hA5A5A5A5});
        @(negedge clk);
        wr_req = 1'b0;
        chk("both_first_is_write", wr_valid_o, 0);
        wait_idle();
        @(negedge clk);
        chk("both_read_accepted", busy_o, 1);
        chk("both_read_wr_valid", wr_valid_o, 1);
        rd_req = 1'b0;
        wait_idle();

        // Out-of-range read and write.
        wr(32'h0, 32'h13579BDF, 4'hF);
        wr(32'h1000, 32'hFFFFFFFF, 4'hF);
        chk("oor_wr_busy", bn, 3);
        rd(32'h1000, 32'h0);
        rd(32'h0, 32'h13579BDF);

        // Reset during WAIT aborts the write.
        wr(32'h8, 32'hCAFEF00D, 4'hF);
        wait_idle();
        wr_req = 1'b1; wr_addr = 32'h8; wr_data = 32'h12345678; wr_byte = 4'hF;
        @(negedge clk);
        wr_req = 1'b0;
        chk("abort_in_wait", busy_o, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", busy_o, 0);
        chk("abort_wr_valid", wr_valid_o, 1);
        chk("abort_rd_data", rd_data_o, 0);
        chk("abort_rd_valid", rd_valid_o, 0);
        chk("abort_err", err_o, 0);
        rd(32'h8, 32'hCAFEF00D);
        rd(32'h20, 32'hA5A5A5A5);

        // Back-to-back reads on LATENCY=1 and LATENCY=8 instances.
        for (int i = 0; i < 2; i++) begin
            last_acc[i] = -1; prev_acc[i] = -1; pulses[i] = 0;
        end
        lat[0] = 1; lat[1] = 8;
        l_req = 2'b11;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (l_rv[i]) begin
                    pulses[i]++;
                    chk("accept_to_valid", 64'(c - last_acc[i]), 64'(lat[i] + 1));
                end
                if (!l_busy[i] && l_req[i]) begin
                    if (last_acc[i] >= 0) begin
                        prev_acc[i] = last_acc[i];
                        chk("request_spacing", 64'(c - prev_acc[i]), 64'(lat[i] + 2));
                    end
                    last_acc[i] = c;
                end
            end
        end
        l_req = 2'b00;
        chk("l1_pulses_seen", pulses[0] >= 2, 1);
        chk("l8_pulses_seen", pulses[1] >= 2, 1);

        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
